ghr_spec_ckpt: RTL and testbench
================================

// Module: ghr_spec_ckpt
// PURPOSE
//  Speculative global history register with in-order checkpoint/recovery for the branch predictor.
//  - Fetch shifts the predicted direction into the speculative history and a checkpoint is queued.
//  - Branches resolve oldest-first.
//  - A correct resolve retires the checkpoint into the committed history.
//  - A mispredict restores the speculative history from the checkpoint and flushes all younger entries.
// PARAMETERS
//  HISTORY_SIZE  64  history length in bits; legal 2..256
//  CKPT_DEPTH    8   max unresolved branches in flight; power of 2, 2..64
//  CNT_W         $clog2(CKPT_DEPTH+1)  width of occupancy count (derived, not overridden)
// PORTS
//  clk               in   1             clock, all state updates on posedge
//  rst_n             in   1             async active-low reset
//  pred_valid        in   1             predicted branch issued this cycle
//  pred_taken        in   1             predicted direction (1 = taken)
//  pred_ready        out  1             !full; pred_valid while !pred_ready is dropped
//  resolve_valid     in   1             oldest in-flight branch resolves this cycle
//  resolve_taken     in   1             actual direction of that branch
//  resolve_mispred   in   1             actual != predicted
//  spec_history      out  HISTORY_SIZE  speculative history; bit0 = newest
//  commit_history    out  HISTORY_SIZE  architectural history; bit0 = newest
//  count             out  CNT_W         checkpoints held
//  empty             out  1             count == 0
//  full              out  1             count == CKPT_DEPTH
//  err_underflow     out  1             sticky: resolve_valid seen while empty
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - spec_history = 0, commit_history = 0, count = 0, rd/wr ptr = 0, err_underflow = 0.
//   - pred_ready = 1, empty = 1, full = 0.
//   - Reset mid-flight discards all checkpoints; no recovery is performed.
//  Storage
//   - Ring buffer of CKPT_DEPTH x HISTORY_SIZE, with wr_ptr/rd_ptr wrapping modulo CKPT_DEPTH.
//   - count tracks occupancy.
//  Predict (pred_valid & pred_ready, no mispredict resolve in the same cycle)
//   - ckpt[wr_ptr] <= spec_history (pre-shift value).
//   - wr_ptr++.
//   - spec_history <= {spec_history[HISTORY_SIZE-2:0], pred_taken}.
//  Correct resolve (resolve_valid & !resolve_mispred & !empty)
//   - rd_ptr++.
//   - commit_history <= {commit_history[HISTORY_SIZE-2:0], resolve_taken}.
//   - spec_history is unaffected.
//  Mispredict (resolve_valid & resolve_mispred & !empty)
//   - spec_history <= {ckpt[rd_ptr][HISTORY_SIZE-2:0], resolve_taken}.
//   - commit_history shifts in resolve_taken.
//   - rd_ptr <= wr_ptr, count <= 0 (flush).
//  Simultaneous events
//   - Predict + correct resolve: both take effect; count unchanged.
//   - Predict + mispredict: mispredict wins; the predict is dropped (it is wrong-path); count -> 0.
//  Edge cases
//   - Resolve while empty: no state change except err_underflow <= 1 (cleared only by reset).
//   - Predict while full: ignored, nothing written.
//   - pred_ready is registered-state only: there is no combinational path from resolve_* to pred_ready.
//  Latency
//   - All outputs reflect an update on the cycle after the triggering edge.
//   - No outputs are combinational from inputs.
//  Invariant: when empty and no mispredict is pending, spec_history == commit_history.
// TESTING
//  T1 reset
//   - Drive inputs at random, assert rst_n=0 mid-cycle.
//   - -> histories 0, count 0, empty=1, pred_ready=1, err_underflow=0 immediately (async).
//  T2 in-order commit
//   - Predict T,N,T then resolve T,N,T, all correct.
//   - -> spec_history = ...0101; commit_history equals it after the 3rd resolve; count back to 0.
//  T3 mispredict recovery
//   - From 0, predict T,T,T,T; then resolve the 1st with mispred=1, taken=0.
//   - -> spec_history = 0, commit_history = 0, count = 0, empty = 1.
//  T4 full / wrap
//   - Predict CKPT_DEPTH (8) times -> full=1, pred_ready=0; a 9th predict is ignored.
//   - Resolve 3 correct, predict 3: pointers wrap; 8 further correct resolves end with commit == spec.
//  T5 simultaneous
//   - count=2; in one cycle assert predict(T) + correct resolve -> count stays 2.
//   - Next cycle: predict + mispredict -> count 0, and spec_history excludes the dropped predict.
//  T6 underflow
//   - resolve_valid while empty -> err_underflow=1, histories unchanged; stays 1 until rst_n=0.

Source files
------------

// File: rtl/ghr_spec_ckpt_if.sv
// Predictor-side bundle for the speculative GHR: predict/resolve handshake plus history/status outputs.
`default_nettype none

interface ghr_spec_ckpt_if #(
  parameter int HISTORY_SIZE = 64,
  parameter int CKPT_DEPTH   = 8
);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);

  logic                    pred_valid;
  logic                    pred_taken;
  logic                    pred_ready;
  logic                    resolve_valid;
  logic                    resolve_taken;
  logic                    resolve_mispred;
  logic [HISTORY_SIZE-1:0] spec_history;
  logic [HISTORY_SIZE-1:0] commit_history;
  logic [CNT_W-1:0]        count;
  logic                    empty;
  logic                    full;
  logic                    err_underflow;

  modport master (
    output pred_valid, pred_taken, resolve_valid, resolve_taken, resolve_mispred,
    input  pred_ready, spec_history, commit_history, count, empty, full, err_underflow
  );

  modport slave (
    input  pred_valid, pred_taken, resolve_valid, resolve_taken, resolve_mispred,
    output pred_ready, spec_history, commit_history, count, empty, full, err_underflow
  );
endinterface

`default_nettype wire

// File: rtl/ghr_spec_ckpt.sv
// Speculative global history register with an in-order checkpoint ring for mispredict recovery.
`default_nettype none

module ghr_spec_ckpt #(
  parameter int HISTORY_SIZE = 64,
  parameter int CKPT_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ghr_spec_ckpt_if.slave bus
);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);
  localparam int PTR_W = $clog2(CKPT_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CKPT_DEPTH);

  logic [HISTORY_SIZE-1:0] ckpt_q [CKPT_DEPTH];
  logic [HISTORY_SIZE-1:0] spec_q, spec_d;
  logic [HISTORY_SIZE-1:0] commit_q, commit_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    err_q, err_d;

  logic empty, full, resolve_ok, pop, flush, push;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign resolve_ok = bus.resolve_valid & ~empty;
  assign flush      = resolve_ok & bus.resolve_mispred;
  assign pop        = resolve_ok & ~bus.resolve_mispred;
  // A predict issued alongside a mispredict is wrong-path and is discarded.
  assign push       = bus.pred_valid & ~full & ~flush;

  always_comb begin
    spec_d   = spec_q;
    commit_d = commit_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (bus.resolve_valid & empty);

    if (resolve_ok) begin
      commit_d = {commit_q[HISTORY_SIZE-2:0], bus.resolve_taken};
    end

    if (flush) begin
      spec_d   = HISTORY_SIZE'({ckpt_q[rd_ptr_q], bus.resolve_taken});
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        spec_d   = {spec_q[HISTORY_SIZE-2:0], bus.pred_taken};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_q   <= '0;
      commit_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      spec_q   <= spec_d;
      commit_q <= commit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Checkpoint payload needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      ckpt_q[wr_ptr_q] <= spec_q;
    end
  end

  assign bus.pred_ready     = ~full;
  assign bus.spec_history   = spec_q;
  assign bus.commit_history = commit_q;
  assign bus.count          = count_q;
  assign bus.empty          = empty;
  assign bus.full           = full;
  assign bus.err_underflow  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ghr_spec_ckpt.sv
// Randomised and directed bench for ghr_spec_ckpt against a queue-based reference model.
`default_nettype none

module tb_ghr_spec_ckpt;
  localparam int HS = 64;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ghr_spec_ckpt_if #(.HISTORY_SIZE(HS), .CKPT_DEPTH(D)) bus ();

  ghr_spec_ckpt #(.HISTORY_SIZE(HS), .CKPT_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Model: each queue entry is the speculative history seen when that branch was predicted.
  logic [HS-1:0] m_spec, m_commit;
  logic [HS-1:0] m_q [$];
  bit            m_uf;
  bit            dq [$];

  task automatic chk(input string tag, input logic [HS-1:0] obs, input logic [HS-1:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".spec"},   bus.spec_history,   m_spec);
    chk({tag, ".commit"}, bus.commit_history, m_commit);
    chk({tag, ".count"},  HS'(bus.count),     HS'(m_q.size()));
    chk({tag, ".empty"},  HS'(bus.empty),     HS'(m_q.size() == 0));
    chk({tag, ".full"},   HS'(bus.full),      HS'(m_q.size() == D));
    chk({tag, ".ready"},  HS'(bus.pred_ready), HS'(m_q.size() != D));
    chk({tag, ".uf"},     HS'(bus.err_underflow), HS'(m_uf));
  endtask

  task automatic model_reset();
    m_spec   = '0;
    m_commit = '0;
    m_q.delete();
    m_uf = 1'b0;
  endtask

  task automatic drive(input bit pv, input bit pt, input bit rv, input bit rt, input bit rm);
    bus.pred_valid      = pv;
    bus.pred_taken      = pt;
    bus.resolve_valid   = rv;
    bus.resolve_taken   = rt;
    bus.resolve_mispred = rm;
  endtask

  task automatic cycle(input bit pv, input bit pt, input bit rv, input bit rt, input bit rm);
    int            sz;
    logic [HS-1:0] pre;
    drive(pv, pt, rv, rt, rm);
    @(posedge clk);
    sz  = m_q.size();
    pre = m_spec;
    if (rv) begin
      if (sz == 0) begin
        m_uf = 1'b1;
      end else begin
        m_commit = {m_commit[HS-2:0], rt};
        if (rm) begin
          m_spec = {m_q[0][HS-2:0], rt};
          m_q.delete();
        end else begin
          void'(m_q.pop_front());
        end
      end
    end
    if (pv && sz < D && !(rv && rm && sz > 0)) begin
      m_q.push_back(pre);
      m_spec = {pre[HS-2:0], pt};
    end
    #1;
    chk_all("cyc");
  endtask

  // Assert reset between clock edges with live random inputs; it must take effect at once.
  task automatic mid_reset();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("rst");
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: reset mid-flight
    for (int i = 0; i < 5; i++) cycle(1, 1'($urandom), 0, 0, 0);
    mid_reset();

    // T2: in-order commit
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("t2_spec", bus.spec_history, 64'h5);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    chk("t2_commit", bus.commit_history, 64'h5);
    chk("t2_count", HS'(bus.count), 64'd0);

    // T3: mispredict recovery on the oldest branch
    mid_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    chk("t3_spec_pre", bus.spec_history, 64'hF);
    cycle(0, 0, 1, 0, 1);
    chk("t3_spec", bus.spec_history, 64'h0);
    chk("t3_empty", HS'(bus.empty), 64'd1);

    // T4: fill, overflow attempt, pointer wrap
    mid_reset();
    for (int i = 0; i < D; i++) begin
      b = 1'($urandom);
      cycle(1, b, 0, 0, 0);
      dq.push_back(b);
    end
    chk("t4_full", HS'(bus.full), 64'd1);
    chk("t4_ready", HS'(bus.pred_ready), 64'd0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, dq.pop_front(), 0);
    for (int i = 0; i < 3; i++) begin
      b = 1'($urandom);
      cycle(1, b, 0, 0, 0);
      dq.push_back(b);
    end
    for (int i = 0; i < D; i++) cycle(0, 0, 1, dq.pop_front(), 0);
    chk("t4_commit_eq_spec", bus.commit_history, bus.spec_history);

    // T5: simultaneous predict with correct resolve, then with mispredict
    mid_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0);
    chk("t5_count", HS'(bus.count), 64'd2);
    cycle(1, 1, 1, 1, 1);
    chk("t5_spec", bus.spec_history, 64'h3);
    chk("t5_count0", HS'(bus.count), 64'd0);

    // T6: underflow is sticky until reset
    mid_reset();
    cycle(0, 0, 1, 1, 1);
    chk("t6_uf", HS'(bus.err_underflow), 64'd1);
    chk("t6_spec", bus.spec_history, 64'h0);
    for (int i = 0; i < 3; i++) cycle(1, 1'($urandom), 0, 0, 0);
    chk("t6_uf_hold", HS'(bus.err_underflow), 64'd1);
    mid_reset();

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        mid_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 2) == 0, 1'($urandom),
              $urandom_range(0, 7) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
